// File: rtl/execute_stage.sv
// Y86-64 style execute stage: ALU, condition codes, branch/cmov condition and RUN/HALT control.
// Optional feature: define EXEC_OVERFLOW_TRAP_EN to halt with instr_err on OPq signed overflow.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic        out_valid,
  output logic [63:0] valE,
  output logic        cnd,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic        halted,
  output logic        instr_err
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [63:0] alu_res;
  logic        alu_of;
  logic        alu_legal;
  logic [63:0] vale_nxt;
  logic        cnd_nxt;
  logic        cond_true;
  logic        cc_we;
  logic        err_set;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  assign halted = (state == S_HALT);
  assign accept = in_valid && (state == S_RUN);

  always_comb begin
    alu_res   = '0;
    alu_of    = 1'b0;
    alu_legal = 1'b1;
    case (ifun)
      4'h0: begin
        alu_res = valB + valA;
        alu_of  = (valA[63] == valB[63]) && (alu_res[63] != valA[63]);
      end
      4'h1: begin
        alu_res = valB - valA;
        alu_of  = (valA[63] != valB[63]) && (alu_res[63] != valB[63]);
      end
      4'h2:    alu_res = valA & valB;
      4'h3:    alu_res = valA ^ valB;
      default: alu_legal = 1'b0;
    endcase
  end

  // Condition reads the CC register as held before the accepting edge.
  always_comb begin
    case (ifun)
      4'h0:    cond_true = 1'b1;
      4'h1:    cond_true = (sf ^ of) | zf;
      4'h2:    cond_true = sf ^ of;
      4'h3:    cond_true = zf;
      4'h4:    cond_true = ~zf;
      4'h5:    cond_true = ~(sf ^ of);
      4'h6:    cond_true = ~(sf ^ of) & ~zf;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    vale_nxt  = '0;
    cnd_nxt   = 1'b0;
    cc_we     = 1'b0;
    err_set   = 1'b0;
    state_nxt = state;
    if (accept) begin
      case (icode)
        4'h0: state_nxt = S_HALT;
        4'h2: begin
          vale_nxt = valA;
          cnd_nxt  = cond_true;
        end
        4'h3: vale_nxt = valC;
        4'h4, 4'h5: vale_nxt = valB + valC;
        4'h6: begin
          if (alu_legal) begin
            vale_nxt = alu_res;
            cc_we    = 1'b1;
`ifdef EXEC_OVERFLOW_TRAP_EN
            if (alu_of) begin
              err_set   = 1'b1;
              state_nxt = S_HALT;
            end
`endif
          end else begin
            err_set = 1'b1;
          end
        end
        4'h7: cnd_nxt = cond_true;
        4'h8, 4'hA: vale_nxt = valB - 64'd8;
        4'h9, 4'hB: vale_nxt = valB + 64'd8;
        4'h1: vale_nxt = '0;
        default: begin
          err_set   = 1'b1;
          state_nxt = S_HALT;
        end
      endcase
    end
  end

  // instr_err is sticky until reset so a halted stage still reports why it stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      valE      <= '0;
      cnd       <= 1'b0;
      zf        <= 1'b1;
      sf        <= 1'b0;
      of        <= 1'b0;
      instr_err <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        valE <= vale_nxt;
        cnd  <= cnd_nxt;
      end
      if (cc_we) begin
        zf <= (alu_res == 64'd0);
        sf <= alu_res[63];
        of <= alu_of;
      end
      if (err_set) instr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC;
  logic        out_valid, cnd, zf, sf, of, halted, instr_err;
  logic [63:0] valE;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC), .out_valid(out_valid), .valE(valE),
    .cnd(cnd), .zf(zf), .sf(sf), .of(of), .halted(halted), .instr_err(instr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    in_valid = v; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 4'h1, 4'h0, '0, '0, '0);
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (zf !== 1'b1)        begin errors++; $display("FAIL reset_zf got %0b exp 1", zf); end
    checks++; if (sf !== 1'b0)        begin errors++; $display("FAIL reset_sf got %0b exp 0", sf); end
    checks++; if (of !== 1'b0)        begin errors++; $display("FAIL reset_of got %0b exp 0", of); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end
    checks++; if (instr_err !== 1'b0) begin errors++; $display("FAIL reset_instr_err got %0b exp 0", instr_err); end
    checks++; if (valE !== 64'd0)     begin errors++; $display("FAIL reset_valE got %h exp 0", valE); end
  endtask

  task automatic test_add_overflow();
    logic exp_trap;
`ifdef EXEC_OVERFLOW_TRAP_EN
    exp_trap = 1'b1;
`else
    exp_trap = 1'b0;
`endif
    do_reset();
    drive(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, '0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %0b exp 1", out_valid); end
    checks++; if (valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_valE got %h exp 8000000000000000", valE); end
    checks++; if ({zf, sf, of} !== 3'b011) begin errors++; $display("FAIL add_cc got zf/sf/of %b exp 011", {zf, sf, of}); end
    checks++; if (instr_err !== exp_trap) begin errors++; $display("FAIL add_instr_err got %0b exp %0b", instr_err, exp_trap); end
    checks++; if (halted !== exp_trap)    begin errors++; $display("FAIL add_halted got %0b exp %0b", halted, exp_trap); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_idle_out_valid got %0b exp 0", out_valid); end

    // sub overflow: 0x8000..0 - 1 wraps to 0x7FFF..F
    do_reset();
    drive(1'b1, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, '0);
    step();
    in_valid = 1'b0;
    checks++; if (valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_ovf_valE got %h exp 7fffffffffffffff", valE); end
    checks++; if ({zf, sf, of} !== 3'b001) begin errors++; $display("FAIL sub_ovf_cc got zf/sf/of %b exp 001", {zf, sf, of}); end
    checks++; if (halted !== exp_trap) begin errors++; $display("FAIL sub_ovf_halted got %0b exp %0b", halted, exp_trap); end
  endtask

  task automatic test_sub_branch();
    do_reset();
    // make zf=0 first so je truly depends on the sub's CC write
    drive(1'b1, 4'h6, 4'h3, 64'h1, 64'h2, '0);
    step();
    drive(1'b1, 4'h6, 4'h1, 64'd5, 64'd5, '0);
    step();
    checks++; if (valE !== 64'd0) begin errors++; $display("FAIL sub_valE got %h exp 0", valE); end
    checks++; if ({zf, sf, of} !== 3'b100) begin errors++; $display("FAIL sub_cc got zf/sf/of %b exp 100", {zf, sf, of}); end
    drive(1'b1, 4'h7, 4'h3, '0, '0, 64'h40);
    step();
    checks++; if (cnd !== 1'b1 || out_valid !== 1'b1 || valE !== 64'd0) begin errors++; $display("FAIL je_cnd got cnd %0b ov %0b valE %h exp 1 1 0", cnd, out_valid, valE); end
    drive(1'b1, 4'h7, 4'h4, '0, '0, 64'h40);
    step();
    checks++; if (cnd !== 1'b0) begin errors++; $display("FAIL jne_cnd got %0b exp 0", cnd); end
    drive(1'b1, 4'h6, 4'h2, 64'hF0, 64'h3C, '0);
    step();
    checks++; if (valE !== 64'h30 || zf !== 1'b0) begin errors++; $display("FAIL and_valE got %h zf %0b exp 30 0", valE, zf); end
    drive(1'b1, 4'h6, 4'h3, 64'hF0, 64'h3C, '0);
    step();
    checks++; if (valE !== 64'hCC) begin errors++; $display("FAIL xor_valE got %h exp cc", valE); end
    drive(1'b1, 4'h2, 4'h4, 64'h55, 64'h99, '0);
    step();
    in_valid = 1'b0;
    checks++; if (valE !== 64'h55 || cnd !== 1'b1) begin errors++; $display("FAIL cmovne got valE %h cnd %0b exp 55 1", valE, cnd); end
  endtask

  task automatic test_stack_mem();
    do_reset();
    drive(1'b1, 4'hA, 4'hF, '0, 64'h100, '0);
    step();
    checks++; if (valE !== 64'hF8) begin errors++; $display("FAIL pushq_valE got %h exp f8", valE); end
    drive(1'b1, 4'hB, 4'hF, '0, 64'h100, '0);
    step();
    checks++; if (valE !== 64'h108) begin errors++; $display("FAIL popq_valE got %h exp 108", valE); end
    drive(1'b1, 4'h4, 4'h0, 64'h77, 64'h10, 64'h8);
    step();
    checks++; if (valE !== 64'h18) begin errors++; $display("FAIL rmmovq_valE got %h exp 18", valE); end
    drive(1'b1, 4'h3, 4'h0, 64'h77, 64'h10, 64'h1234);
    step();
    checks++; if (valE !== 64'h1234) begin errors++; $display("FAIL irmovq_valE got %h exp 1234", valE); end
    drive(1'b1, 4'h8, 4'h0, '0, 64'h0, 64'h500);
    step();
    in_valid = 1'b0;
    checks++; if (valE !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL call_wrap_valE got %h exp fffffffffffffff8", valE); end
    checks++; if ({zf, sf, of} !== 3'b100) begin errors++; $display("FAIL stack_cc got zf/sf/of %b exp 100", {zf, sf, of}); end
  endtask

  task automatic test_illegal_ifun();
    do_reset();
    drive(1'b1, 4'h6, 4'h7, 64'h8000_0000_0000_0000, 64'h1, '0);
    step();
    checks++; if (valE !== 64'd0 || instr_err !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL bad_ifun got valE %h err %0b halted %0b exp 0 1 0", valE, instr_err, halted); end
    checks++; if ({zf, sf, of} !== 3'b100) begin errors++; $display("FAIL bad_ifun_cc got zf/sf/of %b exp 100", {zf, sf, of}); end
    drive(1'b1, 4'h1, 4'h0, '0, '0, '0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bad_ifun_continue got %0b exp 1", out_valid); end
  endtask

  task automatic test_halt();
    do_reset();
    drive(1'b1, 4'h6, 4'h0, 64'h3, 64'h4, '0);
    step();
    drive(1'b1, 4'h0, 4'h0, '0, '0, '0);
    step();
    checks++; if (out_valid !== 1'b1 || valE !== 64'd0 || halted !== 1'b1) begin errors++; $display("FAIL halt_accept got ov %0b valE %h halted %0b exp 1 0 1", out_valid, valE, halted); end
    drive(1'b1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_hold%0d got ov %0b halted %0b exp 0 1", i, out_valid, halted); end
    end
    checks++; if (valE !== 64'd0 || {zf, sf, of} !== 3'b000) begin errors++; $display("FAIL halt_state_hold got valE %h cc %b exp 0 000", valE, {zf, sf, of}); end
    rst = 1'b1;
    drive(1'b1, 4'h1, 4'h0, '0, '0, '0);
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL halt_rst got ov %0b halted %0b exp 0 0", out_valid, halted); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL halt_resume got %0b exp 1", out_valid); end
  endtask

  task automatic test_invalid_icode();
    do_reset();
    drive(1'b1, 4'hC, 4'h0, '0, '0, '0);
    step();
    checks++; if (instr_err !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL icode_c got err %0b halted %0b exp 1 1", instr_err, halted); end
    rst = 1'b1;
    drive(1'b1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, '0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++; if ({out_valid, halted, instr_err, cnd} !== 4'b0000) begin errors++; $display("FAIL rst_prio_flags got ov/h/err/cnd %b exp 0000", {out_valid, halted, instr_err, cnd}); end
    checks++; if ({zf, sf, of} !== 3'b100 || valE !== 64'd0) begin errors++; $display("FAIL rst_prio_cc got cc %b valE %h exp 100 0", {zf, sf, of}, valE); end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h1, 4'h0, '0, '0, '0);
    test_reset();
    test_add_overflow();
    test_sub_branch();
    test_stack_mem();
    test_illegal_ifun();
    test_halt();
    test_invalid_icode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high, sampled on posedge clk.
REQ-003 in_valid  input  1  decoded instruction present on icode/ifun/valA/valB/valC this cycle.
REQ-004 icode  input  4  instruction code from decode (0 halt … B popq).
REQ-005 ifun  input  4  function code (ALU op or condition).
REQ-006 valA, valB, valC  input  64 each  operands from decode/fetch.
REQ-007 out_valid  output  1  registered; result outputs valid this cycle.
REQ-008 valE  output  64  registered ALU result.
REQ-009 cnd  output  1  registered condition result for cmovXX/jXX.
REQ-010 zf, sf, of  output  1 each  current condition-code register.
REQ-011 halted  output  1  stage has accepted halt or invalid instruction.
REQ-012 instr_err  output  1  registered; accepted icode > 4'hB.

Function
REQ-013 Latency: instruction accepted at edge N (in_valid=1, not halted) SHALL produce out_valid=1 with its valE/cnd after edge N; out_valid=0 otherwise.
REQ-014 valE SHALL be: OPq -> ALU(valA,valB); irmovq -> valB+valC... no: irmovq -> 0+valC; rmmovq/mrmovq -> valB+valC; cmovXX -> 0+valA; call/pushq -> valB-8; ret/popq -> valB+8; halt/nop/jXX -> 0.
REQ-015 ALU ifun: 0 valB+valA, 1 valB-valA, 2 valA&valB, 3 valA^valB; other ifun on OPq -> valE=0, CC unchanged, instr_err=1.
REQ-016 Arithmetic SHALL be 64-bit modulo 2^64; carry discarded.
REQ-017 CC SHALL update only on accepted OPq with legal ifun: zf=(result==0), sf=result[63], of=signed overflow (add: operands same sign, result differs; sub: valB, valA differ in sign, result sign != valB sign; and/xor: 0).
REQ-018 cnd SHALL be computed from CC values held before the accepting edge: ifun 0 always, 1 (sf^of)|zf, 2 sf^of, 3 zf, 4 !zf, 5 !(sf^of), 6 !(sf^of)&!zf, other 0; cnd=0 for icodes other than 2 and 7.
REQ-019 Back-to-back OPq then jXX SHALL see the CC written by the OPq.
REQ-020 State machine RUN/HALT: RUN->HALT on accepted icode 0 or icode > B; HALT holds until rst; in HALT in_valid ignored, out_valid=0, CC and valE hold.
REQ-021 The halt instruction itself SHALL produce out_valid=1, valE=0 in the accepting cycle; halted=1 from the same edge.

Reset
REQ-022 On rst=1 at posedge clk: state=RUN, zf=1, sf=0, of=0, valE=0, cnd=0, out_valid=0, halted=0, instr_err=0.
REQ-023 rst SHALL take priority over a simultaneous in_valid; that instruction is discarded.
REQ-024 rst mid-operation (including in HALT) SHALL return to RUN with the values above; no instruction in flight survives.

Configuration
REQ-025 Macro EXEC_OVERFLOW_TRAP_EN: when defined, an accepted OPq setting of=1 SHALL also set instr_err=1 and move to HALT; when undefined, overflow only sets of and execution continues.

Verification
REQ-026 rst, then idle -> zf=1, sf=0, of=0, out_valid=0, halted=0.
REQ-027 OPq add (6/0) valA=0x7FFFFFFFFFFFFFFF valB=1 -> next cycle valE=0x8000000000000000, sf=1, of=1, zf=0; with EXEC_OVERFLOW_TRAP_EN also instr_err=1, halted=1.
REQ-028 OPq sub (6/1) valA=5 valB=5, next cycle jXX je (7/3) -> first valE=0, zf=1; second cnd=1; jne (7/4) gives cnd=0.
REQ-029 pushq valB=0x100 -> valE=0xF8; popq valB=0x100 -> valE=0x108; rmmovq valB=0x10 valC=0x8 -> valE=0x18; CC unchanged throughout.
REQ-030 halt accepted, then nop with in_valid=1 for 3 cycles -> one out_valid pulse, halted=1, out_valid stays 0; rst -> RUN, nop then produces out_valid=1.
REQ-031 icode 4'hC accepted -> instr_err=1, halted=1; rst and in_valid asserted same edge -> all REQ-022 values, out_valid=0.
